// File: rtl/iic_pkg.sv
// Shared definitions for the IIC responder and bus-monitoring helpers:
// FSM encoding, bit positions and line levels.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_ADDR_H,
    ST_ADDR_H_ACK,
    ST_ADDR_L,
    ST_ADDR_L_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } iic_state_e;

  localparam int         RW_BIT       = 0;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'b1010011;

endpackage

// File: rtl/iic_line_sync.sv
// Synchronizes SCL/SDA onto the system clock and flags SCL edges plus
// START/STOP conditions. Needs P_SYNC_STAGES >= 2.
module iic_line_sync #(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [P_SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic                     scl_p1, sda_p1;
  logic                     scl_s;

  // Idle bus is pulled high, so the chain resets to 1 to avoid false edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[P_SYNC_STAGES-2:0], i_scl};
      sda_sync_p0 <= {sda_sync_p0[P_SYNC_STAGES-2:0], i_sda};
      scl_p1      <= scl_s;
      sda_p1      <= sda_s;
    end
  end

  assign scl_s     = scl_sync_p0[P_SYNC_STAGES-1];
  assign sda_s     = sda_sync_p0[P_SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s & scl_p1;
  assign start_det = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_det  = scl_s & scl_p1 & ~sda_p1 & sda_s;

endmodule

// File: rtl/iic_slave_eeprom.sv
// IIC responder emulating a two-byte-address EEPROM on an internal byte
// array; every committed write is mirrored on the o_wr_* monitor port.
module iic_slave_eeprom
  import iic_pkg::*;
#(
  parameter logic [6:0] P_DEVICE_ADDR = DEF_DEV_ADDR,
  parameter int         P_ADDR_WIDTH  = 16,
  parameter int         P_MEM_DEPTH   = 256,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_iic_scl,
  inout  wire                     io_iic_sda,
  output logic                    o_wr_valid,
  output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]              o_wr_data,
  output logic                    o_busy
);

  localparam int                      IDX_W    = $clog2(P_MEM_DEPTH);
  localparam logic [P_ADDR_WIDTH-1:0] IDX_MASK = P_ADDR_WIDTH'(P_MEM_DEPTH - 1);

  // Only the indexed low bits wrap; the upper address bits stay as written.
  function automatic logic [P_ADDR_WIDTH-1:0] ptr_inc(input logic [P_ADDR_WIDTH-1:0] p);
    return (p & ~IDX_MASK) | ((p + P_ADDR_WIDTH'(1)) & IDX_MASK);
  endfunction

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  iic_line_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_line_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_scl     (i_iic_scl),
    .i_sda     (io_iic_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e              state;
  logic [2:0]              bit_cnt;
  logic [7:0]              shreg;
  logic [P_ADDR_WIDTH-1:0] ptr;
  logic                    rw;
  logic                    sda_oe;
  logic                    fall_p1, fall_p2;
  logic [7:0]              mem [P_MEM_DEPTH];
  logic [7:0]              rx_byte;
  logic [P_ADDR_WIDTH-1:0] ptr_nx;
  logic                    mem_we;

  assign rx_byte    = {shreg[6:0], sda_s};
  assign ptr_nx     = ptr_inc(ptr);
  assign mem_we     = scl_rise & ~start_det & ~stop_det & (state == ST_WDATA_ACK);
  assign io_iic_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[ptr[IDX_W-1:0]] <= shreg;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      fall_p1    <= 1'b0;
      fall_p2    <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_wr_valid <= 1'b0;
      // Drive changes lag scl_fall by two cycles to give the master hold time.
      fall_p1    <= scl_fall;
      fall_p2    <= fall_p1;
      if (start_det) begin
        state   <= ST_DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
      end else begin
        if (fall_p2) begin
          case (state)
            ST_DEV_ACK, ST_ADDR_H_ACK, ST_ADDR_L_ACK, ST_WDATA_ACK: sda_oe <= 1'b1;
            ST_RDATA: sda_oe <= ~shreg[7];
            default:  sda_oe <= 1'b0;
          endcase
        end
        if (scl_rise) begin
          case (state)
            ST_DEV, ST_ADDR_H, ST_ADDR_L, ST_WDATA: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ST_DEV: begin
                    if (rx_byte[7:1] == P_DEVICE_ADDR) begin
                      rw     <= rx_byte[RW_BIT];
                      o_busy <= 1'b1;
                      state  <= ST_DEV_ACK;
                    end else begin
                      o_busy <= 1'b0;
                      state  <= ST_WAIT_STOP;
                    end
                  end
                  ST_ADDR_H: begin
                    ptr[P_ADDR_WIDTH-1 -: 8] <= rx_byte;
                    state <= ST_ADDR_H_ACK;
                  end
                  ST_ADDR_L: begin
                    ptr[7:0] <= rx_byte;
                    state    <= ST_ADDR_L_ACK;
                  end
                  default: state <= ST_WDATA_ACK;
                endcase
              end
            end
            ST_DEV_ACK: begin
              bit_cnt <= '0;
              if (rw) begin
                shreg <= mem[ptr[IDX_W-1:0]];
                state <= ST_RDATA;
              end else begin
                state <= ST_ADDR_H;
              end
            end
            ST_ADDR_H_ACK: begin
              bit_cnt <= '0;
              state   <= ST_ADDR_L;
            end
            ST_ADDR_L_ACK, ST_WDATA_ACK: begin
              bit_cnt <= '0;
              state   <= ST_WDATA;
              if (state == ST_WDATA_ACK) begin
                o_wr_valid <= 1'b1;
                o_wr_addr  <= ptr;
                o_wr_data  <= shreg;
                ptr        <= ptr_nx;
              end
            end
            ST_RDATA: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_RDATA_ACK;
            end
            ST_RDATA_ACK: begin
              bit_cnt <= '0;
              ptr     <= ptr_nx;
              if (sda_s == ACK) begin
                shreg <= mem[ptr_nx[IDX_W-1:0]];
                state <= ST_RDATA;
              end else begin
                o_busy <= 1'b0;
                state  <= ST_WAIT_STOP;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
